// File: rtl/ntt_cmd_sequencer.sv
// Command sequencer for the NTT core: queues operation requests, issues them one at a
// time with a start pulse, supervises completion with a timeout, and returns a tagged response.
module ntt_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic       cmd_add_or_sub,
    input  logic [7:0] cmd_off_a,
    input  logic [7:0] cmd_off_b,
    input  logic [7:0] cmd_off_w,
    input  logic [3:0] cmd_tag,
    output logic       core_start,
    output logic [1:0] core_mode,
    output logic       core_add_or_sub,
    output logic [7:0] core_r_start_offset_A,
    output logic [7:0] core_r_start_offset_B,
    output logic [7:0] core_w_data_addr_offset,
    input  logic       core_last_cycle,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_tag,
    output logic       rsp_timeout,
    output logic       busy,
    output logic [3:0] queue_count
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ENT_W = 31;
    localparam logic [3:0]       DEPTH_C   = 4'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [3:0]       r_count;

    state_t           r_state;
    logic [CNT_W-1:0] r_tcnt;
    logic [3:0]       r_tag;
    logic             r_core_start;
    logic [1:0]       r_core_mode;
    logic             r_core_aos;
    logic [7:0]       r_off_a;
    logic [7:0]       r_off_b;
    logic [7:0]       r_off_w;
    logic             r_rsp_valid;
    logic [3:0]       r_rsp_tag;
    logic             r_rsp_timeout;

    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_wr_entry;
    logic [ENT_W-1:0] w_head;
    logic [CNT_W-1:0] w_tcnt_inc;

    // Ready depends only on the registered count, so a pop never frees a slot in the same cycle.
    assign cmd_ready  = (r_count < DEPTH_C);
    assign w_push     = cmd_valid && cmd_ready;
    assign w_pop      = (r_state == S_IDLE) && (r_count != 4'd0);
    assign w_wr_entry = {cmd_mode, cmd_add_or_sub, cmd_off_a, cmd_off_b, cmd_off_w, cmd_tag};
    assign w_head     = r_mem[r_rd_ptr];
    assign w_tcnt_inc = r_tcnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_tcnt        <= '0;
            r_tag         <= 4'd0;
            r_core_start  <= 1'b0;
            r_core_mode   <= 2'd0;
            r_core_aos    <= 1'b0;
            r_off_a       <= 8'd0;
            r_off_b       <= 8'd0;
            r_off_w       <= 8'd0;
            r_rsp_valid   <= 1'b0;
            r_rsp_tag     <= 4'd0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state      <= S_START;
                        r_core_start <= 1'b1;
                        {r_core_mode, r_core_aos, r_off_a, r_off_b, r_off_w, r_tag} <= w_head;
                    end
                end
                S_START: begin
                    r_state <= S_BUSY;
                    r_tcnt  <= '0;
                end
                S_BUSY: begin
                    r_tcnt <= w_tcnt_inc;
                    // Completion takes priority over a timeout in the same cycle.
                    if (core_last_cycle) begin
                        r_state       <= S_RESP;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_tag     <= r_tag;
                        r_rsp_timeout <= 1'b0;
                    end else if (w_tcnt_inc == TIMEOUT_C) begin
                        r_state       <= S_RESP;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_tag     <= r_tag;
                        r_rsp_timeout <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign core_start              = r_core_start;
    assign core_mode               = r_core_mode;
    assign core_add_or_sub         = r_core_aos;
    assign core_r_start_offset_A   = r_off_a;
    assign core_r_start_offset_B   = r_off_b;
    assign core_w_data_addr_offset = r_off_w;
    assign rsp_valid               = r_rsp_valid;
    assign rsp_tag                 = r_rsp_tag;
    assign rsp_timeout             = r_rsp_timeout;
    assign busy                    = (r_state != S_IDLE);
    assign queue_count             = r_count;

endmodule

// File: tb/tb_ntt_cmd_sequencer.sv
// Bench for ntt_cmd_sequencer: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based behavioural model.
module tb_ntt_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_mode = 2'd0;
    logic       cmd_add_or_sub = 1'b0;
    logic [7:0] cmd_off_a = 8'd0;
    logic [7:0] cmd_off_b = 8'd0;
    logic [7:0] cmd_off_w = 8'd0;
    logic [3:0] cmd_tag = 4'd0;
    logic       core_last_cycle = 1'b0;
    logic       rsp_ready = 1'b0;

    logic       cmd_ready, core_start, core_add_or_sub, rsp_valid, rsp_timeout, busy;
    logic [1:0] core_mode;
    logic [7:0] core_r_start_offset_A, core_r_start_offset_B, core_w_data_addr_offset;
    logic [3:0] rsp_tag, queue_count;

    logic       l_cmd_ready, l_core_start, l_core_aos, l_rsp_valid, l_rsp_timeout, l_busy;
    logic [1:0] l_core_mode;
    logic [7:0] l_off_a, l_off_b, l_off_w;
    logic [3:0] l_rsp_tag, l_queue_count;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ntt_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_add_or_sub(cmd_add_or_sub), .cmd_off_a(cmd_off_a),
        .cmd_off_b(cmd_off_b), .cmd_off_w(cmd_off_w), .cmd_tag(cmd_tag),
        .core_start(core_start), .core_mode(core_mode), .core_add_or_sub(core_add_or_sub),
        .core_r_start_offset_A(core_r_start_offset_A), .core_r_start_offset_B(core_r_start_offset_B),
        .core_w_data_addr_offset(core_w_data_addr_offset), .core_last_cycle(core_last_cycle),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
        .busy(busy), .queue_count(queue_count)
    );

    // Second instance with a long timeout, used for the 40-cycle completion scenario.
    ntt_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(1023)) u_long (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(l_cmd_ready),
        .cmd_mode(cmd_mode), .cmd_add_or_sub(cmd_add_or_sub), .cmd_off_a(cmd_off_a),
        .cmd_off_b(cmd_off_b), .cmd_off_w(cmd_off_w), .cmd_tag(cmd_tag),
        .core_start(l_core_start), .core_mode(l_core_mode), .core_add_or_sub(l_core_aos),
        .core_r_start_offset_A(l_off_a), .core_r_start_offset_B(l_off_b),
        .core_w_data_addr_offset(l_off_w), .core_last_cycle(core_last_cycle),
        .rsp_valid(l_rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(l_rsp_tag), .rsp_timeout(l_rsp_timeout),
        .busy(l_busy), .queue_count(l_queue_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a command queue plus the life of the one command in flight.
    typedef struct packed {
        logic [1:0] mode;
        logic       aos;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] w;
        logic [3:0] tag;
    } cmd_t;

    cmd_t       mq[$];
    cmd_t       m_cur = '0;
    cmd_t       m_inc;
    bit         m_push;
    bit         m_active = 1'b0;
    bit         m_start = 1'b0;
    bit         m_rsp = 1'b0;
    int         m_busy_cycles = 0;
    logic [3:0] m_rsp_tag = 4'd0;
    bit         m_rsp_to = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_cur = '0;
            m_active = 1'b0;
            m_start = 1'b0;
            m_rsp = 1'b0;
            m_busy_cycles = 0;
            m_rsp_tag = 4'd0;
            m_rsp_to = 1'b0;
        end else begin
            m_push = cmd_valid && (mq.size() < DEPTH);
            m_inc = {cmd_mode, cmd_add_or_sub, cmd_off_a, cmd_off_b, cmd_off_w, cmd_tag};
            if (!m_active) begin
                if (mq.size() != 0) begin
                    m_cur = mq.pop_front();
                    m_active = 1'b1;
                    m_start = 1'b1;
                end
            end else if (m_start) begin
                m_start = 1'b0;
                m_busy_cycles = 0;
            end else if (m_rsp) begin
                if (rsp_ready) begin
                    m_rsp = 1'b0;
                    m_active = 1'b0;
                end
            end else begin
                m_busy_cycles++;
                if (core_last_cycle || m_busy_cycles == TMO) begin
                    m_rsp = 1'b1;
                    m_rsp_tag = m_cur.tag;
                    m_rsp_to = !core_last_cycle;
                end
            end
            if (m_push) mq.push_back(m_inc);
        end
    end

    logic [3:0] seen_tags[$];
    always @(posedge clk) begin
        if (!rst && rsp_valid && rsp_ready) seen_tags.push_back(rsp_tag);
    end

    bit chk_en = 1'b0;
    int l_starts = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
            check("queue_count", 32'(queue_count), 32'(mq.size()));
            check("core_start", 32'(core_start), 32'(m_start));
            check("busy", 32'(busy), 32'(m_active));
            check("core_mode", 32'(core_mode), 32'(m_cur.mode));
            check("core_add_or_sub", 32'(core_add_or_sub), 32'(m_cur.aos));
            check("off_A", 32'(core_r_start_offset_A), 32'(m_cur.a));
            check("off_B", 32'(core_r_start_offset_B), 32'(m_cur.b));
            check("off_W", 32'(core_w_data_addr_offset), 32'(m_cur.w));
            check("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
            check("rsp_tag", 32'(rsp_tag), 32'(m_rsp_tag));
            check("rsp_timeout", 32'(rsp_timeout), 32'(m_rsp_to));
            if (l_core_start) l_starts++;
        end
    end

    task automatic push_cmd(input logic [3:0] tag, output int waited);
        cmd_mode = 2'($urandom);
        cmd_add_or_sub = 1'($urandom);
        cmd_off_a = 8'($urandom);
        cmd_off_b = 8'($urandom);
        cmd_off_w = 8'($urandom);
        cmd_tag = tag;
        cmd_valid = 1'b1;
        waited = 0;
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) check("push_ready_wait", 32'(waited), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int lat;
        int cnt;
        int w;

        rst = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_queue_count", 32'(queue_count), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_long_idle", 32'({l_busy, l_queue_count, l_cmd_ready}), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single ADDSUB, completion 40 cycles after start (long-timeout instance).
        cmd_mode = 2'd3; cmd_add_or_sub = 1'b1;
        cmd_off_a = 8'd0; cmd_off_b = 8'd32; cmd_off_w = 8'd64; cmd_tag = 4'd5;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        while (!l_core_start && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("t37_start_latency", 32'(lat), 32'd1);
        check("t37_main_start", 32'(core_start), 32'd1);
        repeat (40) begin
            @(negedge clk);
            check("t37_hold_offsets", 32'({l_off_a, l_off_b, l_off_w}), 32'({8'd0, 8'd32, 8'd64}));
        end
        core_last_cycle = 1'b1;
        @(negedge clk);
        core_last_cycle = 1'b0;
        check("t37_rsp_valid", 32'(l_rsp_valid), 32'd1);
        check("t37_rsp_tag", 32'(l_rsp_tag), 32'd5);
        check("t37_rsp_timeout", 32'(l_rsp_timeout), 32'd0);
        check("t37_mode", 32'({l_core_mode, l_core_aos}), 32'd7);
        check("t37_start_pulses", 32'(l_starts), 32'd1);
        check("t37_main_timed_out", 32'({rsp_valid, rsp_timeout, rsp_tag}), 32'h35);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        @(negedge clk);

        // Five commands while busy: queue fills at four, the fifth waits for a pop.
        seen_tags.delete();
        rsp_ready = 1'b1;
        push_cmd(4'd0, w);
        for (int k = 1; k <= 4; k++) push_cmd(4'(k), w);
        check("t38_full_count", 32'(queue_count), 32'd4);
        check("t38_full_ready", 32'(cmd_ready), 32'd0);
        push_cmd(4'd5, w);
        check("t38_fifth_waited", 32'(w > 5), 32'd1);
        cnt = 0;
        while ((busy || queue_count != 4'd0) && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("t38_drained", 32'(busy), 32'd0);
        check("t38_rsp_count", 32'(seen_tags.size()), 32'd6);
        for (int k = 0; k < 6; k++) check("t38_rsp_order", 32'(seen_tags[k]), 32'(k));
        rsp_ready = 1'b0;

        // Timeout with an idle core, then stalled response, then completion on the timeout cycle.
        push_cmd(4'd7, w);
        push_cmd(4'd8, w);
        lat = 0;
        while (!core_start && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        cnt = 0;
        while (!rsp_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("t39_resp_after", 32'(cnt), 32'd16);
        check("t39_rsp_timeout", 32'(rsp_timeout), 32'd1);
        check("t39_rsp_tag", 32'(rsp_tag), 32'd7);
        for (int i = 0; i < 10; i++) begin
            cmd_valid = (i == 2);
            cmd_tag = 4'd9;
            @(negedge clk);
            check("t41_rsp_stable", 32'({rsp_valid, rsp_timeout, rsp_tag}), 32'h37);
            check("t41_no_start", 32'(core_start), 32'd0);
        end
        check("t41_queue_accepts", 32'(queue_count), 32'd2);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t32_idle_gap", 32'({busy, core_start, rsp_valid}), 32'd0);
        @(negedge clk);
        check("t32_next_start", 32'(core_start), 32'd1);
        repeat (15) @(negedge clk);
        core_last_cycle = 1'b1;
        @(negedge clk);
        core_last_cycle = 1'b0;
        check("t40_rsp", 32'({rsp_valid, rsp_timeout, rsp_tag}), 32'h28);

        // Reset while busy with two commands queued.
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        lat = 0;
        while (!core_start && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        push_cmd(4'd10, w);
        push_cmd(4'd11, w);
        check("t42_pre_state", 32'({busy, queue_count}), 32'h12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t42_ctrl", 32'({cmd_ready, core_start, busy, queue_count}), 32'h40);
        check("t42_rsp", 32'({rsp_valid, rsp_tag, rsp_timeout}), 32'd0);
        check("t42_core", 32'({core_mode, core_add_or_sub, core_r_start_offset_A,
                               core_r_start_offset_B, core_w_data_addr_offset}), 32'd0);
        repeat (20) @(negedge clk);
        check("t42_no_response", 32'({rsp_valid, busy}), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_mode = 2'($urandom);
            cmd_add_or_sub = 1'($urandom);
            cmd_off_a = 8'($urandom);
            cmd_off_b = 8'($urandom);
            cmd_off_w = 8'($urandom);
            cmd_tag = 4'($urandom);
            rsp_ready = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            core_last_cycle = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        core_last_cycle = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
